fft_axis_pkt_fifo: RTL and testbench

//  Parametrised single-clock AXI-Stream FIFO with first-word-fall-through output, tlast sideband,

---
 rtl/fft_fifo_pkg.sv | 12 +
 rtl/fft_axis_fifo_ram.sv | 24 ++
 rtl/fft_axis_pkt_fifo.sv | 159 +++++++++++++++
 tb/tb_fft_axis_pkt_fifo.sv | 440 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_fifo_pkg.sv
// Shared constants and sizing helpers for the FFT-side AXI-Stream packet FIFO.
package fft_fifo_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_ADDR_W = 13;

    // Width needed to count 0..depth inclusive.
    function automatic int lvl_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fft_axis_fifo_ram.sv
// Simple dual-port storage for {tlast, tdata}; synchronous read, no reset.
module fft_axis_fifo_ram #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 13
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W:0]   wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W:0]   rdata
);

    logic [DATA_W:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
        if (re)
            rdata <= mem[raddr];
    end

endmodule

// File: rtl/fft_axis_pkt_fifo.sv
// Single-clock AXI-Stream FIFO: FWFT output, tlast sideband, flags, flush and optional
// store-and-forward packet mode.
module fft_axis_pkt_fifo
    import fft_fifo_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter bit PKT_MODE = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic [DATA_W-1:0] s_axis_tdata,
    input  logic              s_axis_tlast,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic              m_axis_tlast,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    input  logic [ADDR_W:0]   cfg_afull_th,
    input  logic [ADDR_W:0]   cfg_aempty_th,
    output logic [ADDR_W:0]   level,
    output logic [ADDR_W:0]   pkt_cnt,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty
);

    localparam int DEPTH = 2**ADDR_W;
    localparam int LVL_W = lvl_width(DEPTH);
    localparam logic [LVL_W-1:0] DEPTH_L = LVL_W'(DEPTH);

    logic [ADDR_W-1:0] wr_ptr, rd_ptr;
    logic [LVL_W-1:0]  level_q, pkt_q, ram_cnt, rd_pkt;
    logic [LVL_W-1:0]  level_nxt, pkt_nxt, ram_cnt_nxt, rd_pkt_nxt;
    logic [DATA_W:0]   ram_q, out_q;
    logic              ram_vld, out_vld, tready_q;
    logic              tlast_d1, tlast_d2;
    logic              wr_acc, rd_acc, wr_last, rd_last;
    logic              ram_rd, out_load, cut_through, pkt_gate;

    // Two-stage FWFT pipeline: RAM read register, then output register.
    assign wr_acc   = s_axis_tvalid & tready_q;
    assign rd_acc   = m_axis_tvalid & m_axis_tready;
    assign wr_last  = wr_acc & s_axis_tlast;
    assign rd_last  = rd_acc & m_axis_tlast;
    assign out_load = ram_vld & (~out_vld | rd_acc);
    assign ram_rd   = (ram_cnt != '0) & (~ram_vld | out_load);

    // A full FIFO with no frame end stored would otherwise never drain.
    assign cut_through = full & (pkt_q == '0);
    assign pkt_gate    = (PKT_MODE == 1'b0) | (rd_pkt != '0) | cut_through;

    assign m_axis_tvalid = out_vld & pkt_gate;
    assign m_axis_tdata  = out_q[DATA_W-1:0];
    assign m_axis_tlast  = out_q[DATA_W];
    assign s_axis_tready = tready_q;

    assign level        = level_q;
    assign pkt_cnt      = pkt_q;
    assign full         = (level_q == DEPTH_L);
    assign empty        = (level_q == '0);
    assign almost_full  = (level_q >= cfg_afull_th);
    assign almost_empty = (level_q <= cfg_aempty_th);

    always_comb begin
        level_nxt = level_q;
        case ({wr_acc, rd_acc})
            2'b10:   level_nxt = level_q + LVL_W'(1);
            2'b01:   level_nxt = level_q - LVL_W'(1);
            default: level_nxt = level_q;
        endcase

        pkt_nxt = pkt_q;
        case ({wr_last, rd_last})
            2'b10:   pkt_nxt = pkt_q + LVL_W'(1);
            2'b01:   pkt_nxt = pkt_q - LVL_W'(1);
            default: pkt_nxt = pkt_q;
        endcase

        ram_cnt_nxt = ram_cnt;
        case ({wr_acc, ram_rd})
            2'b10:   ram_cnt_nxt = ram_cnt + LVL_W'(1);
            2'b01:   ram_cnt_nxt = ram_cnt - LVL_W'(1);
            default: ram_cnt_nxt = ram_cnt;
        endcase

        // Read-side frame count sees a frame end two edges after it is written,
        // matching the time the data itself needs to reach the output.
        rd_pkt_nxt = rd_pkt;
        case ({tlast_d2, rd_last})
            2'b10:   rd_pkt_nxt = rd_pkt + LVL_W'(1);
            2'b01:   rd_pkt_nxt = rd_pkt - LVL_W'(1);
            default: rd_pkt_nxt = rd_pkt;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level_q  <= '0;
            pkt_q    <= '0;
            ram_cnt  <= '0;
            rd_pkt   <= '0;
            ram_vld  <= 1'b0;
            out_vld  <= 1'b0;
            out_q    <= '0;
            tready_q <= 1'b0;
            tlast_d1 <= 1'b0;
            tlast_d2 <= 1'b0;
        end else if (flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level_q  <= '0;
            pkt_q    <= '0;
            ram_cnt  <= '0;
            rd_pkt   <= '0;
            ram_vld  <= 1'b0;
            out_vld  <= 1'b0;
            tready_q <= 1'b0;
            tlast_d1 <= 1'b0;
            tlast_d2 <= 1'b0;
        end else begin
            if (wr_acc)
                wr_ptr <= wr_ptr + ADDR_W'(1);
            if (ram_rd)
                rd_ptr <= rd_ptr + ADDR_W'(1);
            level_q  <= level_nxt;
            pkt_q    <= pkt_nxt;
            ram_cnt  <= ram_cnt_nxt;
            rd_pkt   <= rd_pkt_nxt;
            ram_vld  <= ram_rd | (ram_vld & ~out_load);
            out_vld  <= out_load | (out_vld & ~rd_acc);
            if (out_load)
                out_q <= ram_q;
            // Drop ready in the same cycle the last slot gets used.
            tready_q <= (level_nxt != DEPTH_L);
            tlast_d1 <= wr_last;
            tlast_d2 <= tlast_d1;
        end
    end

    fft_axis_fifo_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (wr_acc & ~flush),
        .waddr (wr_ptr),
        .wdata ({s_axis_tlast, s_axis_tdata}),
        .re    (ram_rd),
        .raddr (rd_ptr),
        .rdata (ram_q)
    );

endmodule

// File: tb/tb_fft_axis_pkt_fifo.sv
// Directed bench for fft_axis_pkt_fifo: a plain FWFT instance and a packet-mode instance.
module tb_fft_axis_pkt_fifo;

    localparam int DW = 16;
    localparam int AW = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush = 1'b0;
    logic [AW:0] afull_th = 5'd12;
    logic [AW:0] aempty_th = 5'd3;

    logic [DW-1:0] s_tdata = '0, m_tdata;
    logic s_tlast = 1'b0, s_tvalid = 1'b0, s_tready;
    logic m_tlast, m_tvalid, m_ready = 1'b0;
    logic [AW:0] level, pkt_cnt;
    logic full, empty, afull, aempty;

    logic [DW-1:0] p_s_tdata = '0, p_m_tdata;
    logic p_s_tlast = 1'b0, p_s_tvalid = 1'b0, p_s_tready;
    logic p_m_tlast, p_m_tvalid, p_m_ready = 1'b0;
    logic [AW:0] p_level, p_pkt_cnt;
    logic p_full, p_empty, p_afull, p_aempty;

    int checks = 0;
    int fails = 0;

    always #5 clk = ~clk;

    fft_axis_pkt_fifo #(.DATA_W(DW), .ADDR_W(AW), .PKT_MODE(1'b0)) u_fifo (
        .clk(clk), .rst(rst), .flush(flush),
        .s_axis_tdata(s_tdata), .s_axis_tlast(s_tlast), .s_axis_tvalid(s_tvalid),
        .s_axis_tready(s_tready),
        .m_axis_tdata(m_tdata), .m_axis_tlast(m_tlast), .m_axis_tvalid(m_tvalid),
        .m_axis_tready(m_ready),
        .cfg_afull_th(afull_th), .cfg_aempty_th(aempty_th),
        .level(level), .pkt_cnt(pkt_cnt), .full(full), .empty(empty),
        .almost_full(afull), .almost_empty(aempty)
    );

    fft_axis_pkt_fifo #(.DATA_W(DW), .ADDR_W(AW), .PKT_MODE(1'b1)) u_pkt (
        .clk(clk), .rst(rst), .flush(flush),
        .s_axis_tdata(p_s_tdata), .s_axis_tlast(p_s_tlast), .s_axis_tvalid(p_s_tvalid),
        .s_axis_tready(p_s_tready),
        .m_axis_tdata(p_m_tdata), .m_axis_tlast(p_m_tlast), .m_axis_tvalid(p_m_tvalid),
        .m_axis_tready(p_m_ready),
        .cfg_afull_th(afull_th), .cfg_aempty_th(aempty_th),
        .level(p_level), .pkt_cnt(p_pkt_cnt), .full(p_full), .empty(p_empty),
        .almost_full(p_afull), .almost_empty(p_aempty)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        step();
        step();
        checks++;
        if (level !== 5'd0 || m_tvalid !== 1'b0 || s_tready !== 1'b0 || empty !== 1'b1 ||
            full !== 1'b0 || pkt_cnt !== 5'd0 || m_tdata !== 16'h0) begin
            fails++;
            $display("FAIL reset_state level=%0d tvalid=%b tready=%b empty=%b (exp 0,0,0,1)",
                     level, m_tvalid, s_tready, empty);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (s_tready !== 1'b0) begin
            fails++;
            $display("FAIL ready_before_edge got=%b exp=0", s_tready);
        end
        step();
        checks++;
        if (s_tready !== 1'b1) begin
            fails++;
            $display("FAIL ready_after_release got=%b exp=1", s_tready);
        end
        s_tvalid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            s_tdata = 16'h0100 + 16'(i);
            step();
        end
        s_tvalid = 1'b0;
        step();
        step();
        checks++;
        if (level !== 5'd3 || m_tvalid !== 1'b1) begin
            fails++;
            $display("FAIL pre_reset level=%0d tvalid=%b exp 3,1", level, m_tvalid);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (level !== 5'd0 || m_tvalid !== 1'b0 || s_tready !== 1'b0 || m_tdata !== 16'h0 ||
            pkt_cnt !== 5'd0) begin
            fails++;
            $display("FAIL async_reset level=%0d tvalid=%b tready=%b tdata=%h exp 0,0,0,0",
                     level, m_tvalid, s_tready, m_tdata);
        end
        step();
        rst = 1'b0;
        step();
        checks++;
        if (s_tready !== 1'b1 || level !== 5'd0) begin
            fails++;
            $display("FAIL ready_after_reset tready=%b level=%0d exp 1,0", s_tready, level);
        end
    endtask

    task automatic test_fill();
        m_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            s_tvalid = 1'b1;
            s_tdata  = 16'(i);
            checks++;
            if (s_tready !== 1'b1) begin
                fails++;
                $display("FAIL fill_ready word=%0d got=%b exp=1", i, s_tready);
            end
            step();
        end
        checks++;
        if (full !== 1'b1 || level !== 5'd16 || s_tready !== 1'b0) begin
            fails++;
            $display("FAIL fill_full full=%b level=%0d tready=%b exp 1,16,0", full, level, s_tready);
        end
        s_tdata = 16'hDEAD;
        step();
        step();
        step();
        checks++;
        if (level !== 5'd16) begin
            fails++;
            $display("FAIL fill_hold level=%0d exp 16", level);
        end
        s_tvalid = 1'b0;
        m_ready  = 1'b1;
        for (int i = 0; i < 16; i++) begin
            for (int t = 0; t < 8 && m_tvalid !== 1'b1; t++)
                step();
            checks++;
            if (m_tvalid !== 1'b1 || m_tdata !== 16'(i)) begin
                fails++;
                $display("FAIL drain_data idx=%0d got=%h valid=%b exp=%h", i, m_tdata, m_tvalid, i);
            end
            step();
        end
        m_ready = 1'b0;
        checks++;
        if (empty !== 1'b1 || level !== 5'd0 || m_tvalid !== 1'b0) begin
            fails++;
            $display("FAIL drain_empty empty=%b level=%0d exp 1,0", empty, level);
        end
    endtask

    task automatic test_back_to_back();
        s_tvalid = 1'b1;
        s_tdata  = 16'h0A00;
        step();
        s_tvalid = 1'b0;
        checks++;
        if (m_tvalid !== 1'b0 || level !== 5'd1) begin
            fails++;
            $display("FAIL lat_n tvalid=%b level=%0d exp 0,1", m_tvalid, level);
        end
        step();
        checks++;
        if (m_tvalid !== 1'b0) begin
            fails++;
            $display("FAIL lat_n1 tvalid=%b exp 0", m_tvalid);
        end
        step();
        checks++;
        if (m_tvalid !== 1'b1 || m_tdata !== 16'h0A00) begin
            fails++;
            $display("FAIL lat_n2 tvalid=%b tdata=%h exp 1,0a00", m_tvalid, m_tdata);
        end
        s_tvalid = 1'b1;
        for (int i = 1; i < 3; i++) begin
            s_tdata = 16'h0A00 + 16'(i);
            step();
        end
        s_tvalid = 1'b0;
        step();
        step();
        m_ready  = 1'b1;
        s_tvalid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            s_tdata = 16'h0A03 + 16'(i);
            checks++;
            if (m_tvalid !== 1'b1 || s_tready !== 1'b1 || m_tdata !== 16'h0A00 + 16'(i)) begin
                fails++;
                $display("FAIL b2b_data i=%0d got=%h v=%b r=%b exp=%h", i, m_tdata, m_tvalid,
                         s_tready, 16'h0A00 + 16'(i));
            end
            step();
            checks++;
            if (level !== 5'd3) begin
                fails++;
                $display("FAIL b2b_level i=%0d got=%0d exp=3", i, level);
            end
        end
        s_tvalid = 1'b0;
        for (int i = 20; i < 23; i++) begin
            for (int t = 0; t < 8 && m_tvalid !== 1'b1; t++)
                step();
            checks++;
            if (m_tvalid !== 1'b1 || m_tdata !== 16'h0A00 + 16'(i)) begin
                fails++;
                $display("FAIL b2b_tail i=%0d got=%h exp=%h", i, m_tdata, 16'h0A00 + 16'(i));
            end
            step();
        end
        m_ready = 1'b0;
        checks++;
        if (empty !== 1'b1) begin
            fails++;
            $display("FAIL b2b_empty empty=%b exp 1", empty);
        end
    endtask

    task automatic test_stream();
        int wi = 0;
        int ri = 0;
        int mlev = 0;
        int cyc = 0;
        logic wa, ra;
        while (ri < 1000 && cyc < 10000) begin
            s_tvalid = (wi < 1000);
            s_tdata  = 16'(wi);
            s_tlast  = (wi % 8 == 7);
            m_ready  = 1'($urandom_range(0, 1));
            #1;
            wa = s_tvalid & s_tready;
            ra = m_tvalid & m_ready;
            if (ra) begin
                checks++;
                if (m_tdata !== 16'(ri) || m_tlast !== (ri % 8 == 7)) begin
                    fails++;
                    $display("FAIL stream_data idx=%0d got=%h/%b exp=%h/%b", ri, m_tdata, m_tlast,
                             16'(ri), (ri % 8 == 7));
                end
            end
            step();
            if (wa) wi++;
            if (ra) ri++;
            mlev = mlev + int'(wa) - int'(ra);
            checks++;
            if (int'(level) != mlev || level > 5'd16) begin
                fails++;
                $display("FAIL stream_level cyc=%0d got=%0d exp=%0d", cyc, level, mlev);
            end
            cyc++;
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        m_ready  = 1'b0;
        checks++;
        if (ri != 1000 || pkt_cnt !== 5'd0 || empty !== 1'b1) begin
            fails++;
            $display("FAIL stream_done read=%0d pkt_cnt=%0d exp 1000,0", ri, pkt_cnt);
        end
    endtask

    task automatic test_thresholds();
        checks++;
        if (afull !== 1'b0 || aempty !== 1'b1) begin
            fails++;
            $display("FAIL th_level0 afull=%b aempty=%b exp 0,1", afull, aempty);
        end
        s_tvalid = 1'b1;
        for (int lvl = 1; lvl <= 12; lvl++) begin
            s_tdata = 16'(lvl);
            step();
            checks++;
            if (int'(level) != lvl || afull !== (lvl >= 12) || aempty !== (lvl <= 3)) begin
                fails++;
                $display("FAIL th_fill lvl=%0d got=%0d af=%b ae=%b", lvl, level, afull, aempty);
            end
        end
        s_tvalid = 1'b0;
        for (int lvl = 11; lvl >= 2; lvl--) begin
            m_ready = 1'b1;
            step();
            m_ready = 1'b0;
            checks++;
            if (int'(level) != lvl || afull !== (lvl >= 12) || aempty !== (lvl <= 3)) begin
                fails++;
                $display("FAIL th_drain lvl=%0d got=%0d af=%b ae=%b", lvl, level, afull, aempty);
            end
        end
        aempty_th = 5'd1;
        #1;
        checks++;
        if (aempty !== 1'b0) begin
            fails++;
            $display("FAIL th_live aempty=%b exp 0", aempty);
        end
        aempty_th = 5'd3;
    endtask

    task automatic test_flush();
        s_tvalid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            s_tdata = 16'h0300 + 16'(i);
            step();
        end
        checks++;
        if (level !== 5'd7) begin
            fails++;
            $display("FAIL flush_pre level=%0d exp 7", level);
        end
        flush   = 1'b1;
        s_tdata = 16'hBEEF;
        step();
        flush    = 1'b0;
        s_tvalid = 1'b0;
        checks++;
        if (level !== 5'd0 || empty !== 1'b1 || m_tvalid !== 1'b0 || pkt_cnt !== 5'd0) begin
            fails++;
            $display("FAIL flush_clear level=%0d empty=%b tvalid=%b exp 0,1,0", level, empty, m_tvalid);
        end
        step();
        checks++;
        if (s_tready !== 1'b1) begin
            fails++;
            $display("FAIL flush_ready got=%b exp 1", s_tready);
        end
        s_tvalid = 1'b1;
        s_tdata  = 16'h0042;
        step();
        s_tvalid = 1'b0;
        for (int t = 0; t < 6 && m_tvalid !== 1'b1; t++)
            step();
        checks++;
        if (m_tvalid !== 1'b1 || m_tdata !== 16'h0042 || level !== 5'd1) begin
            fails++;
            $display("FAIL flush_next tdata=%h level=%0d exp 0042,1", m_tdata, level);
        end
        m_ready = 1'b1;
        step();
        m_ready = 1'b0;
        checks++;
        if (empty !== 1'b1) begin
            fails++;
            $display("FAIL flush_drain empty=%b exp 1", empty);
        end
    endtask

    task automatic test_pkt_mode();
        p_m_ready  = 1'b0;
        p_s_tvalid = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            p_s_tdata = 16'(i);
            p_s_tlast = (i == 5);
            step();
            checks++;
            if (p_m_tvalid !== 1'b0) begin
                fails++;
                $display("FAIL pkt_hold word=%0d tvalid=%b exp 0", i, p_m_tvalid);
            end
        end
        p_s_tvalid = 1'b0;
        p_s_tlast  = 1'b0;
        checks++;
        if (p_pkt_cnt !== 5'd1) begin
            fails++;
            $display("FAIL pkt_cnt got=%0d exp 1", p_pkt_cnt);
        end
        step();
        checks++;
        if (p_m_tvalid !== 1'b0) begin
            fails++;
            $display("FAIL pkt_n1 tvalid=%b exp 0", p_m_tvalid);
        end
        step();
        checks++;
        if (p_m_tvalid !== 1'b1 || p_m_tdata !== 16'd1) begin
            fails++;
            $display("FAIL pkt_n2 tvalid=%b tdata=%h exp 1,0001", p_m_tvalid, p_m_tdata);
        end
        p_m_ready = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            checks++;
            if (p_m_tvalid !== 1'b1 || p_m_tdata !== 16'(i) || p_m_tlast !== (i == 5)) begin
                fails++;
                $display("FAIL pkt_drain i=%0d got=%h/%b v=%b", i, p_m_tdata, p_m_tlast, p_m_tvalid);
            end
            step();
        end
        p_m_ready = 1'b0;
        checks++;
        if (p_pkt_cnt !== 5'd0 || p_empty !== 1'b1) begin
            fails++;
            $display("FAIL pkt_empty pkt_cnt=%0d empty=%b exp 0,1", p_pkt_cnt, p_empty);
        end
        p_s_tvalid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            p_s_tdata = 16'h0200 + 16'(i);
            step();
        end
        p_s_tvalid = 1'b0;
        checks++;
        if (p_full !== 1'b1 || p_m_tvalid !== 1'b1 || p_m_tdata !== 16'h0200) begin
            fails++;
            $display("FAIL pkt_cutthrough full=%b tvalid=%b tdata=%h exp 1,1,0200",
                     p_full, p_m_tvalid, p_m_tdata);
        end
        flush = 1'b1;
        step();
        flush = 1'b0;
        checks++;
        if (p_level !== 5'd0 || p_m_tvalid !== 1'b0) begin
            fails++;
            $display("FAIL pkt_flush level=%0d tvalid=%b exp 0,0", p_level, p_m_tvalid);
        end
        step();
    endtask

    initial begin
        test_reset();
        test_fill();
        test_back_to_back();
        test_stream();
        test_thresholds();
        test_flush();
        test_pkt_mode();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d fails=%0d", checks, fails);
        $fatal(1, "watchdog");
    end

endmodule
